// File: rtl/tick_alarm.sv
// rtl/tick_alarm.sv - deadline timer on the free-running ticks count
// One-shot relative/absolute and drift-free periodic alarms with ack'd pending flag and overrun count.
module tick_alarm #(
  parameter int WIDTH = 32,
  parameter int OVR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ticks,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             cmd_err,
  output logic             fire,
  output logic             pending,
  input  logic             ack,
  output logic [OVR_W-1:0] overruns,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    ARMED_ONESHOT  = 2'd1,
    ARMED_PERIODIC = 2'd2
  } state_t;

  localparam logic [1:0] OP_REL      = 2'd0;
  localparam logic [1:0] OP_PERIODIC = 2'd1;
  localparam logic [1:0] OP_CANCEL   = 2'd2;
  localparam logic [1:0] OP_ABS      = 2'd3;

  state_t           st;
  logic [WIDTH-1:0] deadline;
  logic [WIDTH-1:0] period;

  logic             cmd_take;
  logic             expired;
  logic             late;
  logic             reject;
  logic             ovr_bump;
  logic [WIDTH-1:0] next_dl;

  assign state    = st;
  assign cmd_take = cmd_valid & cmd_ready;

  // Sign of the modulo difference: reached when the deadline is up to half the range in the past.
  assign expired  = (st != IDLE) && !(1'((ticks - deadline) >> (WIDTH - 1)));
  assign next_dl  = deadline + period;
  assign late     = (st == ARMED_PERIODIC) && !(1'((ticks - next_dl) >> (WIDTH - 1)));

  always_comb begin
    reject = 1'b0;
    case (cmd_op)
      OP_PERIODIC: reject = (cmd_arg == '0) || cmd_arg[WIDTH-1];
      OP_CANCEL:   reject = 1'b0;
      default:     reject = cmd_arg[WIDTH-1];
    endcase
  end

  // A late and unacked event still counts as one lost event.
  assign ovr_bump = late || (pending && !ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      deadline  <= '0;
      period    <= '0;
      fire      <= 1'b0;
      pending   <= 1'b0;
      overruns  <= '0;
      cmd_err   <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      cmd_ready <= 1'b1;
      fire      <= 1'b0;
      cmd_err   <= 1'b0;
      if (cmd_take) begin
        if (ack) pending <= 1'b0;
        if (reject) begin
          cmd_err <= 1'b1;
          st      <= IDLE;
        end else begin
          case (cmd_op)
            OP_REL: begin
              deadline <= ticks + cmd_arg;
              overruns <= '0;
              st       <= ARMED_ONESHOT;
            end
            OP_PERIODIC: begin
              deadline <= ticks + cmd_arg;
              period   <= cmd_arg;
              overruns <= '0;
              st       <= ARMED_PERIODIC;
            end
            OP_ABS: begin
              deadline <= cmd_arg;
              overruns <= '0;
              st       <= ARMED_ONESHOT;
            end
            default: st <= IDLE;
          endcase
        end
      end else if (expired) begin
        fire    <= 1'b1;
        pending <= 1'b1;
        if (ovr_bump && !(&overruns)) overruns <= overruns + 1'b1;
        if (st == ARMED_ONESHOT) begin
          st <= IDLE;
        end else if (late) begin
          deadline <= ticks + period;
        end else begin
          deadline <= next_dl;
        end
      end else if (ack) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_alarm.sv
// tb/tb_tick_alarm.sv - scoreboard bench for tick_alarm
// Stimulus pushes expected fire/cmd_err events; a negedge monitor pops and compares them.
module tb_tick_alarm;

  logic        clk;
  logic        rst;
  logic [31:0] ticks;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_err;
  logic        fire;
  logic        pending;
  logic        ack;
  logic [7:0]  overruns;
  logic [1:0]  state;

  tick_alarm #(.WIDTH(32), .OVR_W(8)) dut (
    .clk(clk), .rst(rst), .ticks(ticks),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_err(cmd_err), .fire(fire), .pending(pending), .ack(ack),
    .overruns(overruns), .state(state)
  );

  typedef struct {
    int         cyc;
    bit         err;
    bit         pend;
    logic [7:0] ovr;
    logic [1:0] st;
  } ev_t;

  ev_t  q[$];
  ev_t  e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   stall = 0;
  int   n;
  int   m;
  logic [31:0] t0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (fire || cmd_err) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d fire=%0b cmd_err=%0b", cyc, fire, cmd_err);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || cmd_err != e.err || fire != !e.err || pending != e.pend ||
            overruns != e.ovr || state != e.st) begin
          miscompares++;
          $display("FAIL event: got cyc=%0d fire=%0b err=%0b pend=%0b ovr=%0d st=%0d expected cyc=%0d err=%0b pend=%0b ovr=%0d st=%0d",
                   cyc, fire, cmd_err, pending, overruns, state, e.cyc, e.err, e.pend, e.ovr, e.st);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!stall) ticks = ticks + 32'd1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic expect_ev(input int c, input bit err, input bit pend, input logic [7:0] ovr, input logic [1:0] st);
    ev_t x;
    x.cyc = c; x.err = err; x.pend = pend; x.ovr = ovr; x.st = st;
    q.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ticks = '0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; ack = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {19'd0, fire, cmd_err, pending, overruns, state}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;

    // Relative one-shot, delta 5, accepted in cycle 10
    wait_until(10);
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
    expect_ev(16, 0, 1, 8'd0, 2'd0);
    issue(2'd0, 32'd5);
    check("oneshot_state", {30'd0, state}, 32'd1);
    wait_until(20);
    check("oneshot_pending", {31'd0, pending}, 32'd1);
    check("oneshot_idle", {30'd0, state}, 32'd0);
    do_ack();
    check("ack_clears", {31'd0, pending}, 32'd0);

    // Wrap-around deadline, then a rejected absolute arm while armed
    ticks = 32'hFFFF_FFFA;
    n = cyc;
    expect_ev(n + 11, 0, 1, 8'd0, 2'd0);
    issue(2'd0, 32'd10);
    wait_until(n + 12);
    do_ack();
    issue(2'd0, 32'd100);
    n = cyc;
    expect_ev(n + 1, 1, 0, 8'd0, 2'd0);
    issue(2'd3, 32'h8000_0000);
    check("reject_idle", {30'd0, state}, 32'd0);
    repeat (110) tick();

    // Periodic P=4 with ack on every fire, then cancel
    n = cyc;
    for (int k = 0; k < 20; k++) expect_ev(n + 5 + 4 * k, 0, 1, 8'd0, 2'd2);
    issue(2'd1, 32'd4);
    for (int k = 0; k < 20; k++) begin
      wait_until(n + 5 + 4 * k);
      do_ack();
    end
    issue(2'd2, 32'd0);
    check("cancel_idle", {30'd0, state}, 32'd0);
    check("periodic_no_ovr", {24'd0, overruns}, 32'd0);
    repeat (20) tick();

    // Periodic P=3, never acked: overruns climbs and saturates
    n = cyc;
    for (int k = 0; k < 258; k++) expect_ev(n + 4 + 3 * k, 0, 1, (k > 255) ? 8'd255 : 8'(k), 2'd2);
    issue(2'd1, 32'd3);
    wait_until(n + 4 + 3 * 257);
    issue(2'd2, 32'd0);
    check("ovr_saturated", {24'd0, overruns}, 32'd255);
    n = cyc;
    expect_ev(n + 1, 1, 1, 8'd255, 2'd0);
    issue(2'd1, 32'd0);
    repeat (5) tick();

    // Catch-up after a stalled then jumping timebase
    do_ack();
    n = cyc;
    t0 = ticks;
    expect_ev(n + 6, 0, 1, 8'd0, 2'd2);
    issue(2'd1, 32'd5);
    wait_until(n + 6);
    stall = 1'b1;
    repeat (3) tick();
    ticks = t0 + 32'd20;
    stall = 1'b0;
    m = cyc;
    expect_ev(m + 1, 0, 1, 8'd1, 2'd2);
    expect_ev(m + 6, 0, 1, 8'd1, 2'd2);
    expect_ev(m + 11, 0, 1, 8'd1, 2'd2);
    for (int j = 0; j < 3; j++) begin
      wait_until(m + 1 + 5 * j);
      do_ack();
    end
    issue(2'd2, 32'd0);
    repeat (10) tick();

    // Cancel in the exact expiry cycle
    n = cyc;
    issue(2'd0, 32'd3);
    wait_until(n + 3);
    issue(2'd2, 32'd0);
    check("cancel_collide_idle", {30'd0, state}, 32'd0);
    repeat (10) tick();

    // Ack coinciding with a fire while pending is already set
    n = cyc;
    expect_ev(n + 3, 0, 1, 8'd0, 2'd0);
    issue(2'd0, 32'd2);
    wait_until(n + 4);
    n = cyc;
    expect_ev(n + 4, 0, 1, 8'd0, 2'd0);
    issue(2'd0, 32'd3);
    wait_until(n + 3);
    do_ack();
    tick();
    check("ack_fire_pending", {31'd0, pending}, 32'd1);
    check("ack_fire_ovr", {24'd0, overruns}, 32'd0);

    // Asynchronous reset while armed periodic
    n = cyc;
    expect_ev(n + 3, 0, 1, 8'd1, 2'd2);
    issue(2'd1, 32'd2);
    wait_until(n + 5);
    check("pre_rst_fire", {31'd0, fire}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {19'd0, fire, cmd_err, pending, overruns, state}, 32'd0);
    check("async_rst_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("post_rst_idle", {30'd0, state}, 32'd0);

    check("events_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tick_alarm.md
# tick_alarm

Programmable deadline timer that consumes the free-running `ticks` count from the clock-domain timebase and raises an event when a requested deadline is reached. It supports one-shot relative, one-shot absolute and drift-free periodic alarms, with wrap-around-safe comparison, a level interrupt with acknowledge, and a saturating overrun count. One instance sits beside the timebase for each software- or FSM-owned timeout.

## Interface
- `WIDTH`, 32: width of `ticks`, deadline and argument.
- `OVR_W`, 8: width of the overrun counter.
- `clk` in 1: system clock, the same clock as the timebase.
- `rst` in 1: asynchronous, active-high reset.
- `ticks` in WIDTH: timebase count; advances by 1 per `clk` and wraps modulo 2^WIDTH.
- `cmd_valid` in 1: command strobe.
- `cmd_ready` out 1: command accept; a command is taken on a `clk` edge when `cmd_valid & cmd_ready`.
- `cmd_op` in 2: 0 = arm relative one-shot, 1 = arm periodic, 2 = cancel, 3 = arm absolute one-shot.
- `cmd_arg` in WIDTH: delta/period for ops 0 and 1, deadline for op 3, ignored for op 2.
- `cmd_err` out 1: one-cycle pulse when an accepted command is rejected.
- `fire` out 1: one-cycle pulse per expiry.
- `pending` out 1: set by expiry, cleared by `ack`.
- `ack` in 1: clears `pending`.
- `overruns` out OVR_W: saturating count of lost or late events; cleared by any accepted arm command.
- `state` out 2: 0 = IDLE, 1 = ARMED_ONESHOT, 2 = ARMED_PERIODIC.

## Operation
- Reset values: `state` = IDLE, deadline = 0, period = 0, `fire` = 0, `pending` = 0, `overruns` = 0, `cmd_err` = 0. `cmd_ready` is 0 while `rst` is high and 1 in every state afterwards.
- Expiry test, used only in the ARMED states: `expired = ~(ticks - deadline)[WIDTH-1]`. The difference is taken modulo 2^WIDTH, so a deadline counts as reached when it lies 0 to 2^(WIDTH-1)-1 ticks in the past.
- Op 0: deadline ← `ticks` + `cmd_arg`, next state ARMED_ONESHOT.
- Op 1: deadline ← `ticks` + `cmd_arg`, period ← `cmd_arg`, next state ARMED_PERIODIC.
- Op 3: deadline ← `cmd_arg`, next state ARMED_ONESHOT.
- Op 2: next state IDLE. `pending` and `overruns` are left unchanged.
- Rejection rules:
  - Op 0 or op 3 with `cmd_arg[WIDTH-1]` = 1 is rejected.
  - Op 1 with `cmd_arg` = 0 or `cmd_arg[WIDTH-1]` = 1 is rejected.
  - A rejected command pulses `cmd_err` and returns the block to IDLE.
  - A rejected command does not clear `overruns`.
- Expiry in ARMED_ONESHOT: pulse `fire`, set `pending`, next state IDLE.
- Expiry in ARMED_PERIODIC: pulse `fire`, set `pending`, and compute next = deadline + period.
  - If next is not yet expired against the current `ticks`: deadline ← next (drift-free).
  - Otherwise (catch-up): deadline ← `ticks` + period and `overruns` increments.
- A fire while `pending` = 1 (and not acked in the same cycle) increments `overruns`.
- A single event that is both late and unacked increments `overruns` once, not twice.
- `overruns` saturates at 2^OVR_W-1.
- Simultaneous events:
  - An accepted command and an expiry in the same cycle: the command wins and no fire occurs.
  - `ack` together with a fire: `pending` stays 1 and `overruns` does not increment.

## Timing
- Every output is registered.
- A command accepted at the edge ending cycle N takes effect from cycle N+1, including `state` and `cmd_err` (high in N+1 only).
- Expiry is evaluated on cycle M's `ticks` value. `fire` is high in cycle M+1, and `pending` is 1 from cycle M+1.
- A relative arm with delta d accepted in cycle N fires in cycle N+max(d,1)+1. A delta of 0 fires in cycle N+2.
- Periodic mode with period P gives `fire` pulses exactly P cycles apart, with no cumulative drift.
- `ack` sampled at the edge ending cycle K makes `pending` = 0 from cycle K+1.
- `rst` asserted mid-operation forces all outputs to their reset values immediately (asynchronous). Release is synchronous to `clk`.

## Test plan
- Reset, then op 0 with `cmd_arg`=5 accepted in cycle 10 → `state`=1 in cycle 11, `fire` only in cycle 16, `pending`=1 from 16, `state`=0 from 16.
- Wrap-around: `ticks` = 0xFFFF_FFFA, op 0 with `cmd_arg`=10 → deadline 0x0000_0004, fire one cycle after `ticks`=4. Also op 3 with `cmd_arg`=0x8000_0000 → `cmd_err` pulse, `state`=0.
- Periodic: op 1 with `cmd_arg`=4, `ack` each fire → fires every 4 cycles for 20 periods, `overruns`=0. Then cancel → no further fire and `state`=0.
- Overrun: op 1 with period 3, never ack → second fire sets `overruns`=1. Force `overruns` to 255 and fire again → it stays 255.
- Catch-up: stall `ticks` in the bench, then jump it past next by 10 → one fire, deadline = `ticks`+period, `overruns` +1 (once), then regular spacing resumes.
- Collisions: cancel in the exact expiry cycle → no fire. `ack` in a fire cycle → `pending`=1 with `overruns` unchanged. `rst` pulsed while ARMED → all outputs at reset values the same cycle, and no fire afterwards.
